// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Word-addressed memory bus between the load/store unit
//               (master) and the data memory (slave). A transfer completes
//               on the cycle where bus_valid and bus_ready are both high.
//   bus_valid  master->slave  request present, fields stable until ready
//   bus_we     master->slave  1 = store, 0 = load
//   bus_addr   master->slave  word-aligned byte address
//   bus_wdata  master->slave  store data, already lane-replicated
//   bus_wstrb  master->slave  byte enables for stores, 0000 for loads
//   bus_ready  slave->master  transfer accepted / read data valid
//   bus_rdata  slave->master  full 32-bit read word
// Revision    : 1.0  initial release
// ============================================================================
interface load_store_unit_if;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    output bus_wstrb,
    input  bus_ready,
    input  bus_rdata
  );

  modport slave (
    input  bus_valid,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    input  bus_wstrb,
    output bus_ready,
    output bus_rdata
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RV32 load/store unit. Accepts a load or store from control,
//               formats it onto a word-addressed memory bus, stalls the core
//               until the bus responds (or times out), and returns aligned,
//               sign/zero-extended load data.
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   mem_read    load request
//   mem_write   store request (wins if both requests are high)
//   funct3      access size/sign, instruction[14:12]
//   address     byte address from the ALU
//   write_data  store data (rs2)
//   read_data   registered, extended load result
//   stall       freezes PC / register-file write while high
//   misaligned  illegal funct3 or misaligned access (no bus transfer issued)
//   bus_error   one-cycle pulse when the bus times out
//   bus         memory bus master port
// Parameter   : MAX_WAIT  ACCESS cycles without bus_ready before timeout (>=1)
// Revision    : 1.0  initial release
// ============================================================================
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  wire logic        clock,
  input  wire logic        reset,
  input  wire logic        mem_read,
  input  wire logic        mem_write,
  input  wire logic [2:0]  funct3,
  input  wire logic [31:0] address,
  input  wire logic [31:0] write_data,
  output logic      [31:0] read_data,
  output logic             stall,
  output logic             misaligned,
  output logic             bus_error,
  load_store_unit_if.master bus
);

  // The counter must be able to hold MAX_WAIT itself.
  localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state_q,     state_d;
  logic [WAIT_W-1:0] wait_cnt_q,  wait_cnt_d;
  logic [31:0]       read_data_q, read_data_d;
  logic              bus_error_q, bus_error_d;
  logic [31:0]       addr_q,      addr_d;
  logic              we_q,        we_d;
  logic [3:0]        wstrb_q,     wstrb_d;
  logic [31:0]       wdata_q,     wdata_d;
  logic [2:0]        funct3_q,    funct3_d;
  logic [1:0]        off_q,       off_d;

  logic        w_req;
  logic        w_legal;
  logic        w_aligned;
  logic        w_accept;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [15:0] w_lane;
  logic [31:0] w_load;

  // --------------------------------------------------------------------------
  // Request decode (only meaningful in IDLE)
  // --------------------------------------------------------------------------
  assign w_req = mem_read | mem_write;

  always_comb begin
    w_legal = 1'b0;
    if (mem_write) begin
      w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
    end
  end

  // funct3[1:0] encodes the access size for every legal code.
  always_comb begin
    w_aligned = 1'b0;
    case (funct3[1:0])
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~address[0];
      2'b10:   w_aligned = (address[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  assign w_accept   = (state_q == S_IDLE) && w_req && w_legal && w_aligned;
  assign misaligned = (state_q == S_IDLE) && w_req && !(w_legal && w_aligned);
  assign stall      = w_accept || (state_q == S_ACCESS);

  // --------------------------------------------------------------------------
  // Store lane formatting: data is replicated so the strobe alone picks lanes
  // --------------------------------------------------------------------------
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = write_data;
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: begin
          w_wstrb = 4'b0001 << address[1:0];
          w_wdata = {4{write_data[7:0]}};
        end
        2'b01: begin
          w_wstrb = address[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{write_data[15:0]}};
        end
        default: begin
          w_wstrb = 4'b1111;
          w_wdata = write_data;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Load extraction: bring the addressed byte/halfword down to bit 0
  // --------------------------------------------------------------------------
  always_comb begin
    w_lane = bus.bus_rdata[15:0];
    case (off_q)
      2'd0:    w_lane = bus.bus_rdata[15:0];
      2'd1:    w_lane = bus.bus_rdata[23:8];
      2'd2:    w_lane = bus.bus_rdata[31:16];
      default: w_lane = {8'h00, bus.bus_rdata[31:24]};
    endcase
  end

  always_comb begin
    w_load = bus.bus_rdata;
    case (funct3_q)
      3'b000:  w_load = {{24{w_lane[7]}},  w_lane[7:0]};
      3'b001:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load = {24'h000000, w_lane[7:0]};
      3'b101:  w_load = {16'h0000,   w_lane[15:0]};
      default: w_load = bus.bus_rdata;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM next-state and datapath updates
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    read_data_d = read_data_q;
    bus_error_d = 1'b0;
    addr_d      = addr_q;
    we_d        = we_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    off_d       = off_q;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          state_d    = S_ACCESS;
          wait_cnt_d = '0;
          addr_d     = {address[31:2], 2'b00};
          we_d       = mem_write;
          wstrb_d    = w_wstrb;
          wdata_d    = w_wdata;
          funct3_d   = funct3;
          off_d      = address[1:0];
        end
      end

      S_ACCESS: begin
        if (bus.bus_ready) begin
          state_d = S_DONE;
          if (!we_q) begin
            read_data_d = w_load;
          end
        end else if (wait_cnt_q == LAST_WAIT) begin
          // This miss brings the count to MAX_WAIT: give up on the bus.
          state_d     = S_DONE;
          wait_cnt_d  = wait_cnt_q + 1'b1;
          bus_error_d = 1'b1;
          read_data_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      // One unstalled cycle so the core commits; requests are not sampled here.
      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      read_data_q <= '0;
      bus_error_q <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      read_data_q <= read_data_d;
      bus_error_q <= bus_error_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign read_data     = read_data_q;
  assign bus_error     = bus_error_q;
  // Derived from state so reset drops it without waiting for a clock edge.
  assign bus.bus_valid = (state_q == S_ACCESS);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wstrb = wstrb_q;
  assign bus.bus_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. Directed scenarios
//               plus randomized loads/stores with random bus wait states,
//               compared against a behavioural model of the access rules.
// Revision    : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

  localparam int unsigned MAXW = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        stall;
  logic        misaligned;
  logic        bus_error;

  load_store_unit_if bus_if();

  load_store_unit #(.MAX_WAIT(MAXW)) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .stall      (stall),
    .misaligned (misaligned),
    .bus_error  (bus_error),
    .bus        (bus_if.master)
  );

  always #5 clock = ~clock;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_rd  = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_bad(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    int unsigned sz;
    if (st) legal = (f3 <= 3'd2);
    else    legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    if (!legal) return 1'b1;
    sz = 1 << (f3 % 4);
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
    logic [31:0] sh, v;
    sh = rdata >> (8 * (a % 4));
    case (f3)
      3'd0: begin v = sh % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
      3'd1: begin v = sh % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
      3'd4: v = sh % 256;
      3'd5: v = sh % 65536;
      default: v = rdata;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_strb(input bit st, input logic [2:0] f3, input logic [31:0] a);
    if (!st) return 32'h0;
    case (f3)
      3'd0:    return 32'(1 << (a % 4));
      3'd1:    return ((a % 4) >= 2) ? 32'hC : 32'h3;
      default: return 32'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'd0:    return (wd % 256) * 32'h0101_0101;
      3'd1:    return (wd % 65536) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  // One complete request. Entered and left just after a rising edge, DUT idle.
  task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdata, input int waits);
    bit          st, bad, tmo;
    logic [31:0] e_addr, e_strb, e_wdata;
    st      = wr;
    bad     = model_bad(st, f3, addr);
    e_addr  = addr & 32'hFFFF_FFFC;
    e_strb  = model_strb(st, f3, addr);
    e_wdata = model_wdata(f3, wd);
    tmo     = 1'b0;

    mem_read = rd; mem_write = wr; funct3 = f3; address = addr; write_data = wd;
    bus_if.bus_ready = 1'($urandom);   // must be ignored while idle
    bus_if.bus_rdata = $urandom;
    @(negedge clock);
    check_eq("req_misaligned", 32'(misaligned), 32'(bad));
    check_eq("req_stall", 32'(stall), 32'(!bad));
    check_eq("req_valid", 32'(bus_if.bus_valid), 32'h0);
    @(posedge clock); #1;
    mem_read = 1'b0; mem_write = 1'b0;

    if (bad) begin
      @(negedge clock);
      check_eq("bad_no_valid", 32'(bus_if.bus_valid), 32'h0);
      check_eq("bad_no_stall", 32'(stall), 32'h0);
      @(posedge clock); #1;
      return;
    end

    // Inputs wander during the access; bus fields must not.
    address = $urandom; funct3 = 3'($urandom); write_data = $urandom;
    for (int k = 0; k < int'(MAXW); k++) begin
      bus_if.bus_ready = (k == waits);
      bus_if.bus_rdata = (k == waits) ? rdata : $urandom;
      @(negedge clock);
      check_eq("acc_valid", 32'(bus_if.bus_valid), 32'h1);
      check_eq("acc_stall", 32'(stall), 32'h1);
      check_eq("acc_addr", bus_if.bus_addr, e_addr);
      check_eq("acc_we", 32'(bus_if.bus_we), 32'(st));
      check_eq("acc_wstrb", 32'(bus_if.bus_wstrb), e_strb);
      if (st) check_eq("acc_wdata", bus_if.bus_wdata, e_wdata);
      @(posedge clock); #1;
      if (k == waits) break;
      if (k == int'(MAXW) - 1) tmo = 1'b1;
    end

    if (tmo)      exp_rd = '0;
    else if (!st) exp_rd = model_load(f3, addr, rdata);

    // DONE: a legal request here must not be taken.
    mem_read = 1'b1; funct3 = 3'b010; address = 32'h0; bus_if.bus_ready = 1'b1;
    @(negedge clock);
    check_eq("done_stall", 32'(stall), 32'h0);
    check_eq("done_valid", 32'(bus_if.bus_valid), 32'h0);
    check_eq("done_bus_error", 32'(bus_error), 32'(tmo));
    check_eq("done_read_data", read_data, exp_rd);
    @(posedge clock); #1;
    mem_read = 1'b0;
    @(negedge clock);
    check_eq("idle_stall", 32'(stall), 32'h0);
    check_eq("idle_valid", 32'(bus_if.bus_valid), 32'h0);
    check_eq("idle_bus_error", 32'(bus_error), 32'h0);
    check_eq("idle_read_data", read_data, exp_rd);
    @(posedge clock); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_valid"},   32'(bus_if.bus_valid), 32'h0);
    check_eq({tag, "_stall"},   32'(stall), 32'h0);
    check_eq({tag, "_rd"},      read_data, 32'h0);
    check_eq({tag, "_addr"},    bus_if.bus_addr, 32'h0);
    check_eq({tag, "_wdata"},   bus_if.bus_wdata, 32'h0);
    check_eq({tag, "_wstrb"},   32'(bus_if.bus_wstrb), 32'h0);
    check_eq({tag, "_we"},      32'(bus_if.bus_we), 32'h0);
    check_eq({tag, "_buserr"},  32'(bus_error), 32'h0);
  endtask

  initial begin
    bus_if.bus_ready = 1'b0;
    bus_if.bus_rdata = '0;
    #2;
    check_reset_values("por");
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;

    // LB 0x103 -> sign-extended 0x80, ready on first access cycle
    run_txn(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0);
    check_eq("lb_103_value", read_data, 32'hFFFF_FF80);
    // LHU 0x102 with 3 waits
    run_txn(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'hBEEF_0000, 3);
    check_eq("lhu_102_value", read_data, 32'h0000_BEEF);
    // SB 0x201 (read_data must stay)
    run_txn(1'b0, 1'b1, 3'b000, 32'h201, 32'h0000_00AB, 32'h0, 1);
    check_eq("sb_keeps_rd", read_data, 32'h0000_BEEF);
    // both requests high -> store
    run_txn(1'b1, 1'b1, 3'b001, 32'h302, 32'h1234_5678, 32'hFFFF_FFFF, 0);
    // LW misaligned, illegal store code
    run_txn(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
    run_txn(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
    // LW timeout
    run_txn(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 100);
    check_eq("timeout_rd", read_data, 32'h0);
    // load just before the timeout limit completes normally
    run_txn(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'hCAFE_F00D, int'(MAXW) - 1);

    for (int i = 0; i < 60; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      run_txn(kind != 1, kind != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
              $urandom, $urandom_range(0, 5));
    end

    // reset in the middle of an access
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; address = 32'h500;
    bus_if.bus_ready = 1'b0;
    @(posedge clock); #1;
    mem_read = 1'b0;
    @(negedge clock);
    check_eq("pre_rst_valid", 32'(bus_if.bus_valid), 32'h1);
    #1 reset = 1'b0;
    #1 check_reset_values("mid_rst");
    @(negedge clock);
    reset = 1'b1;
    exp_rd = '0;
    @(posedge clock); #1;
    @(negedge clock);
    check_eq("post_rst_valid", 32'(bus_if.bus_valid), 32'h0);
    check_eq("post_rst_stall", 32'(stall), 32'h0);
    @(posedge clock); #1;
    run_txn(1'b1, 1'b0, 3'b100, 32'h503, 32'h0, 32'h7F00_0000, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
